// File: rtl/parity_frame_ctrl.sv
// Frame sequencer for parity_bit_gen: takes a word over valid/ready, clears the generator,
// shifts the word out MSB first, appends the generator's parity bit and cross-checks it.
module parity_frame_ctrl #(
    parameter int   NUM_BITS        = 8,
    parameter logic EVEN_PARITY_BIT = 1'b1,
    parameter int   GAP_CYCLES      = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_BITS-1:0] in_word,
    input  logic                in_valid,
    output logic                in_ready,
    output logic                pg_clr,
    output logic                pg_wr_en,
    output logic                pg_data,
    input  logic                pg_parity,
    output logic                tx_data,
    output logic                tx_valid,
    output logic                tx_last,
    output logic                parity_err,
    output logic [15:0]         frame_cnt
);

    localparam int            CW       = $clog2(NUM_BITS);
    localparam logic [CW-1:0] LAST_BIT = CW'(NUM_BITS - 1);
    localparam logic [3:0]    GAP_LAST = (GAP_CYCLES == 0) ? 4'd0 : 4'(GAP_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CLEAR  = 3'd1,
        SHIFT  = 3'd2,
        WAIT   = 3'd3,
        PARITY = 3'd4,
        GAP    = 3'd5
    } state_t;

    function automatic logic word_parity(input logic [NUM_BITS-1:0] w);
        return (^w) ^ EVEN_PARITY_BIT;
    endfunction

    state_t                state_r, state_s;
    logic [NUM_BITS-1:0]   shreg_r;
    logic                  ref_r;
    logic [CW-1:0]         bit_cnt_r;
    logic [3:0]            gap_cnt_r;
    logic                  hs_s;

    logic in_ready_r, pg_clr_r, pg_wr_en_r, pg_data_r, tx_data_r, tx_valid_r, tx_last_r;
    logic parity_err_r;
    logic [15:0] frame_cnt_r;
    logic in_ready_s, pg_clr_s, pg_wr_en_s, pg_data_s, tx_data_s, tx_valid_s, tx_last_s;
    logic err_set_s;

    assign hs_s = in_valid & in_ready_r;

    // State and output registers; outputs are precomputed from the next state
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= IDLE;
            in_ready_r   <= 1'b0;
            pg_clr_r     <= 1'b1;
            pg_wr_en_r   <= 1'b0;
            pg_data_r    <= 1'b0;
            tx_data_r    <= 1'b0;
            tx_valid_r   <= 1'b0;
            tx_last_r    <= 1'b0;
            parity_err_r <= 1'b0;
            frame_cnt_r  <= 16'd0;
        end else begin
            state_r    <= state_s;
            in_ready_r <= in_ready_s;
            pg_clr_r   <= pg_clr_s;
            pg_wr_en_r <= pg_wr_en_s;
            pg_data_r  <= pg_data_s;
            tx_data_r  <= tx_data_s;
            tx_valid_r <= tx_valid_s;
            tx_last_r  <= tx_last_s;
            if (err_set_s) begin
                parity_err_r <= 1'b1;
            end
            if (state_s == PARITY) begin
                frame_cnt_r <= frame_cnt_r + 16'd1;
            end
        end
    end

    // Next-state logic
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE:    if (hs_s) state_s = CLEAR; else state_s = IDLE;
            CLEAR:   state_s = SHIFT;
            SHIFT:   if (bit_cnt_r == LAST_BIT) state_s = WAIT; else state_s = SHIFT;
            WAIT:    state_s = PARITY;
            PARITY:  if (GAP_CYCLES == 0) state_s = IDLE; else state_s = GAP;
            GAP:     if (gap_cnt_r == GAP_LAST) state_s = IDLE; else state_s = GAP;
            default: state_s = IDLE;
        endcase
    end

    // Output values for the coming cycle; pg_parity is settled during WAIT
    always_comb begin
        in_ready_s = (state_s == IDLE);
        pg_clr_s   = (state_s == CLEAR);
        pg_wr_en_s = 1'b0;
        pg_data_s  = 1'b0;
        tx_data_s  = 1'b0;
        tx_valid_s = 1'b0;
        tx_last_s  = 1'b0;
        err_set_s  = 1'b0;
        case (state_s)
            SHIFT: begin
                pg_wr_en_s = 1'b1;
                pg_data_s  = shreg_r[NUM_BITS-1];
                tx_data_s  = shreg_r[NUM_BITS-1];
                tx_valid_s = 1'b1;
            end
            PARITY: begin
                tx_data_s  = pg_parity;
                tx_valid_s = 1'b1;
                tx_last_s  = 1'b1;
                err_set_s  = (pg_parity != ref_r);
            end
            default: begin
                pg_wr_en_s = 1'b0;
            end
        endcase
    end

    // Shift register, reference parity and position counters
    always_ff @(posedge clk) begin
        if (rst) begin
            shreg_r   <= '0;
            ref_r     <= 1'b0;
            bit_cnt_r <= '0;
            gap_cnt_r <= 4'd0;
        end else begin
            if (hs_s) begin
                shreg_r <= in_word;
                ref_r   <= word_parity(in_word);
            end else if (state_s == SHIFT) begin
                shreg_r <= {shreg_r[NUM_BITS-2:0], 1'b0};
            end
            if (state_r == SHIFT) begin
                bit_cnt_r <= bit_cnt_r + CW'(1);
            end else begin
                bit_cnt_r <= '0;
            end
            if (state_r == GAP) begin
                gap_cnt_r <= gap_cnt_r + 4'd1;
            end else begin
                gap_cnt_r <= 4'd0;
            end
        end
    end

    assign in_ready   = in_ready_r;
    assign pg_clr     = pg_clr_r;
    assign pg_wr_en   = pg_wr_en_r;
    assign pg_data    = pg_data_r;
    assign tx_data    = tx_data_r;
    assign tx_valid   = tx_valid_r;
    assign tx_last    = tx_last_r;
    assign parity_err = parity_err_r;
    assign frame_cnt  = frame_cnt_r;

endmodule

// File: tb/tb_parity_frame_ctrl.sv
// Bench for parity_frame_ctrl: a schedule-based frame model plus a behavioural parity
// generator drive and check the controller every cycle.
module tb_parity_frame_ctrl;

    localparam int   N     = 8;
    localparam int   G     = 2;
    localparam logic EVEN  = 1'b1;
    localparam int   FRAME = N + 4 + G;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  in_word = 8'h00;
    logic        in_valid = 1'b0;
    logic        in_ready, pg_clr, pg_wr_en, pg_data, pg_parity;
    logic        tx_data, tx_valid, tx_last, parity_err;
    logic [15:0] frame_cnt;
    logic        gen_r = 1'b0;
    logic        inject = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    parity_frame_ctrl #(.NUM_BITS(N), .EVEN_PARITY_BIT(EVEN), .GAP_CYCLES(G)) dut (
        .clk(clk), .rst(rst), .in_word(in_word), .in_valid(in_valid), .in_ready(in_ready),
        .pg_clr(pg_clr), .pg_wr_en(pg_wr_en), .pg_data(pg_data), .pg_parity(pg_parity),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_last(tx_last),
        .parity_err(parity_err), .frame_cnt(frame_cnt)
    );

    // Behavioural parity generator, optionally with its output inverted
    always @(posedge clk) begin
        if (pg_clr) gen_r <= EVEN;
        else if (pg_wr_en) gen_r <= gen_r ^ pg_data;
    end
    assign pg_parity = gen_r ^ inject;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Frame model: a frame is just "cycles since handshake"; everything else follows from that
    bit          m_init = 0, m_after_rst = 0, m_busy = 0, m_inj = 0;
    int          m_d = 0, m_hs_cnt = 0;
    logic [7:0]  m_word = 8'h00;
    logic        m_err = 1'b0;
    logic [15:0] m_cnt = 16'h0000;

    always @(posedge clk) begin
        bit ready;
        if (rst) begin
            m_init = 1; m_after_rst = 1; m_busy = 0; m_d = 0; m_err = 1'b0; m_cnt = 16'h0000;
        end else if (m_init) begin
            ready = !m_busy && !m_after_rst;
            m_after_rst = 0;
            if (m_busy) begin
                if (m_d == N + 2) begin
                    m_cnt = m_cnt + 16'd1;
                    if (m_inj) m_err = 1'b1;
                end
                m_d++;
                if (m_d == FRAME) m_busy = 0;
            end else if (ready && in_valid) begin
                m_busy = 1; m_d = 1; m_word = in_word; m_inj = inject; m_hs_cnt++;
            end
        end
    end

    logic [8:0] cap = 9'h000;
    logic [8:0] last_frame = 9'h000;
    logic [8:0] frames[$];

    // Per-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        logic e_rdy, e_clr, e_val, e_last, e_wr, e_bit;
        if (m_init) begin
            e_rdy = 1'b0; e_clr = 1'b0; e_val = 1'b0; e_last = 1'b0; e_wr = 1'b0; e_bit = 1'b0;
            if (m_after_rst) begin
                e_clr = 1'b1;
            end else if (!m_busy) begin
                e_rdy = 1'b1;
            end else begin
                e_clr = (m_d == 1);
                if (m_d >= 2 && m_d <= N + 1) begin
                    e_val = 1'b1; e_wr = 1'b1; e_bit = m_word[N + 1 - m_d];
                end
                if (m_d == N + 3) begin
                    e_val = 1'b1; e_last = 1'b1; e_bit = (^m_word) ^ EVEN ^ m_inj;
                end
            end
            check("in_ready", in_ready, e_rdy);
            check("pg_clr", pg_clr, e_clr);
            check("pg_wr_en", pg_wr_en, e_wr);
            check("tx_valid", tx_valid, e_val);
            check("tx_last", tx_last, e_last);
            check("parity_err", parity_err, m_err);
            check("frame_cnt", frame_cnt, m_cnt);
            if (e_val) check("tx_data", tx_data, e_bit);
            if (e_wr) check("pg_data", pg_data, e_bit);
            if (tx_valid === 1'b1) cap = {cap[7:0], tx_data};
            if (tx_last === 1'b1) begin
                last_frame = cap;
                frames.push_back(cap);
            end
        end
    end

    task automatic wait_idle();
        int n = 0;
        while ((m_busy || m_after_rst) && n < 100) begin
            @(posedge clk); #1; n++;
        end
        if (n >= 100) check("wait_idle_timeout", 32'd1, 32'd0);
    endtask

    task automatic wait_hs(input int prev);
        int n = 0;
        do begin
            @(posedge clk); #1; n++;
        end while (m_hs_cnt == prev && n < 50);
        if (m_hs_cnt == prev) check("handshake_timeout", 32'd1, 32'd0);
    endtask

    task automatic send(input logic [7:0] w, input bit inj);
        wait_idle();
        inject = inj; in_word = w; in_valid = 1'b1;
        wait_hs(m_hs_cnt);
        in_valid = 1'b0; in_word = 8'($urandom);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [7:0] w[5];
        int n;
        repeat (2) @(posedge clk);
        #1;
        check("reset_in_ready", in_ready, 1'b0);
        check("reset_pg_clr", pg_clr, 1'b1);
        check("reset_tx_valid", tx_valid, 1'b0);
        rst = 1'b0;

        // Known word 0xA5
        send(8'hA5, 1'b0);
        wait_idle();
        check("t1_frame_bits", last_frame, 9'h14B);
        check("t1_frame_cnt", frame_cnt, 16'd1);
        check("t1_parity_err", parity_err, 1'b0);

        // 0x07 gives parity 0; ready returns FRAME cycles after the handshake
        wait_idle();
        in_word = 8'h07; in_valid = 1'b1;
        wait_hs(m_hs_cnt);
        in_valid = 1'b0;
        n = 1;
        while (in_ready !== 1'b1 && n < 40) begin
            @(posedge clk); #1; n++;
        end
        check("t2_ready_latency", n, FRAME);
        check("t2_frame_bits", last_frame, 9'h00E);

        // Back-to-back frames with in_valid held high
        do_reset();
        wait_idle();
        frames.delete();
        for (int i = 0; i < 5; i++) w[i] = 8'($urandom);
        inject = 1'b0; in_word = w[0]; in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            wait_hs(m_hs_cnt);
            if (i < 4) in_word = w[i + 1];
            else in_valid = 1'b0;
        end
        wait_idle();
        check("t3_frame_cnt", frame_cnt, 16'd5);
        check("t3_frames", frames.size(), 5);
        for (int i = 0; i < 5 && i < frames.size(); i++)
            check("t3_frame_word", frames[i], {w[i], (^w[i]) ^ 1'b1});

        // Corrupted generator result, then good frames keep the error sticky
        send(8'($urandom), 1'b1);
        wait_idle();
        check("t4_err_set", parity_err, 1'b1);
        send(8'($urandom), 1'b0);
        send(8'($urandom), 1'b0);
        wait_idle();
        check("t4_err_sticky", parity_err, 1'b1);
        do_reset();
        check("t4_err_cleared", parity_err, 1'b0);

        // Reset during the fourth shifted bit aborts the frame
        wait_idle();
        in_word = 8'($urandom); in_valid = 1'b1;
        wait_hs(m_hs_cnt);
        in_valid = 1'b0;
        n = 0;
        while (m_d != 5 && n < 20) begin
            @(posedge clk); #1; n++;
        end
        check("t5_at_bit4", tx_valid, 1'b1);
        do_reset();
        check("t5_tx_valid", tx_valid, 1'b0);
        check("t5_tx_last", tx_last, 1'b0);
        check("t5_pg_clr", pg_clr, 1'b1);
        check("t5_in_ready", in_ready, 1'b0);
        wait_idle();
        repeat (FRAME) @(posedge clk);
        #1;
        check("t5_frame_cnt", frame_cnt, 16'd0);

        // Counter wrap from a preloaded value
        wait_idle();
        dut.frame_cnt_r = 16'hFFFF;
        m_cnt = 16'hFFFF;
        @(negedge clk);
        check("t6_preload", frame_cnt, 16'hFFFF);
        send(8'h3C, 1'b0);
        wait_idle();
        check("t6_wrap", frame_cnt, 16'h0000);

        // Randomized traffic with idle gaps, ignored in_valid and occasional aborts
        for (int i = 0; i < 30; i++) begin
            wait_idle();
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
            send(8'($urandom), ($urandom_range(0, 3) == 0));
            if ($urandom_range(0, 1) == 1) begin
                in_valid = 1'b1;
                repeat ($urandom_range(1, 5)) @(posedge clk);
                #1;
                in_valid = 1'b0;
            end
            if ($urandom_range(0, 9) == 0) begin
                repeat ($urandom_range(0, 10)) @(posedge clk);
                #1;
                do_reset();
            end
        end
        wait_idle();
        repeat (3) @(posedge clk);
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
